// File: rtl/bcd_down_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_timer_pkg
// Description : Shared definitions for the BCD countdown timer: FSM state
//               encoding, BCD digit constants and the preset-digit clamp.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_down_timer_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Any nibble above 9 is not a legal BCD digit; saturate it to 9.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] i_d);
    return (i_d > DIGIT_MAX) ? DIGIT_MAX : i_d;
  endfunction

endpackage : bcd_down_timer_pkg
`default_nettype wire

// File: rtl/b10_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : b10_down_digit
// Description : Single base-10 down-counting digit with preset load and
//               borrow in/out for cascading least-significant digit first.
// Ports       : clock, reset (sync, active-high), load, d[3:0] preset,
//               ei borrow in / decrement enable, q[3:0] digit value,
//               eu borrow out (combinational, ei & q == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module b10_down_digit
  import bcd_down_timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       ei,
  output logic [3:0] q,
  output logic       eu
);

  logic [3:0] r_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= 4'd0;
    end else if (load) begin
      r_q <= clamp_digit(d);
    end else if (ei) begin
      // 0 wraps to 9; the borrow out below tells the next digit to decrement.
      r_q <= (r_q == 4'd0) ? DIGIT_MAX : (r_q - 4'd1);
    end
  end

  assign q  = r_q;
  assign eu = ei & (r_q == 4'd0);

endmodule : b10_down_digit
`default_nettype wire

// File: rtl/bcd_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_timer
// Description : Multi-digit BCD countdown timer. A chain of down-counting
//               digits is sequenced by an IDLE / RUN / EXPIRED state machine.
// Ports       : clock, reset (sync, active-high), load + d preset,
//               start (IDLE -> RUN), ei decrement enable, eu borrow out,
//               q current BCD count, zero (registered count == 0),
//               done (registered one-cycle pulse on entry to EXPIRED)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  start,
  input  logic                  ei,
  output logic                  eu,
  output logic [4*DIGITS-1:0]   q,
  output logic                  zero,
  output logic                  done
);

  localparam int                  c_cnt_w = DIGIT_W * DIGITS;
  localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_zero;
  logic                 r_done;
  logic                 w_zero_nxt;
  logic                 w_done_nxt;
  logic                 w_dec;
  logic                 w_is_one;
  logic [c_cnt_w-1:0]   w_q;
  logic [DIGITS:0]      w_borrow;
  logic                 w_unused_borrow;

  // Decrement only in RUN, never in a load cycle, and never from zero so the
  // count cannot wrap under FSM control.
  assign w_dec       = ei & (r_state == RUN) & ~load & ~r_zero;
  assign w_borrow[0] = w_dec;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      b10_down_digit u_digit (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .d     (d[DIGIT_W*gi +: DIGIT_W]),
        .ei    (w_borrow[gi]),
        .q     (w_q[DIGIT_W*gi +: DIGIT_W]),
        .eu    (w_borrow[gi+1])
      );
    end
  endgenerate

  // The top digit's borrow out is always 0 because w_dec excludes a zero count.
  assign w_unused_borrow = w_borrow[DIGITS];

  assign w_is_one = (w_q == c_one);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          w_state_nxt = r_zero ? EXPIRED : RUN;
        end
      end
      RUN: begin
        if (load) begin
          w_state_nxt = IDLE;
        end else if (w_dec && w_is_one) begin
          w_state_nxt = EXPIRED;
        end
      end
      EXPIRED: begin
        if (load) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Predict the zero flag for the count being written this edge so that it
  // changes together with q. A clamped preset is zero only if d itself is
  // zero, and a decrement lands on zero only from a count of one.
  always_comb begin
    w_zero_nxt = r_zero;
    if (load) begin
      w_zero_nxt = (d == '0);
    end else if (w_dec) begin
      w_zero_nxt = w_is_one;
    end
  end

  assign w_done_nxt = (w_state_nxt == EXPIRED) && (r_state != EXPIRED);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_zero  <= w_zero_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign q    = w_q;
  assign zero = r_zero;
  assign done = r_done;
  assign eu   = ei & r_zero & (r_state == RUN);

endmodule : bcd_down_timer
`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_down_timer
// Description : Self-checking bench for bcd_down_timer (DIGITS = 4) and a
//               standalone b10_down_digit cell.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_down_timer;

  logic        clock;
  logic        reset;
  logic        load;
  logic [15:0] d;
  logic        start;
  logic        ei;
  logic        eu;
  logic [15:0] q;
  logic        zero;
  logic        done;

  logic        dg_reset;
  logic        dg_load;
  logic [3:0]  dg_d;
  logic        dg_ei;
  logic [3:0]  dg_q;
  logic        dg_eu;

  int n_checks = 0;
  int n_errors = 0;

  bcd_down_timer #(.DIGITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .d     (d),
    .start (start),
    .ei    (ei),
    .eu    (eu),
    .q     (q),
    .zero  (zero),
    .done  (done)
  );

  b10_down_digit dut_digit (
    .clock (clock),
    .reset (dg_reset),
    .load  (dg_load),
    .d     (dg_d),
    .ei    (dg_ei),
    .q     (dg_q),
    .eu    (dg_eu)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] q;
    logic        zero;
    logic        done;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ld;
    logic        st;
    logic        e;
    logic [15:0] dv;
    logic [15:0] eq;
    logic        ez;
    logic        ed;
    logic        eeu;
    string       nm;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          div;
    r   = '0;
    div = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  // Drive one cycle on the falling edge, check eu before the rising edge,
  // then pop the registered expectation one step after the rising edge.
  task automatic step(input logic rst, input logic ld, input logic st, input logic e,
                      input logic [15:0] dv, input logic [15:0] eq, input logic ez,
                      input logic ed, input logic eeu, input string nm);
    exp_t x;
    @(negedge clock);
    reset = rst;
    load  = ld;
    start = st;
    ei    = e;
    d     = dv;
    #1;
    chk(nm, "eu", {31'd0, eu}, {31'd0, eeu});
    x.q    = eq;
    x.zero = ez;
    x.done = ed;
    sb.push_back(x);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk(nm, "scoreboard", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk(nm, "q",    {16'd0, q},    {16'd0, x.q});
      chk(nm, "zero", {31'd0, zero}, {31'd0, x.zero});
      chk(nm, "done", {31'd0, done}, {31'd0, x.done});
    end
  endtask

  task automatic dstep(input logic rst, input logic ld, input logic [3:0] dv, input logic e,
                       input logic eeu, input logic [3:0] eq, input string nm);
    @(negedge clock);
    dg_reset = rst;
    dg_load  = ld;
    dg_d     = dv;
    dg_ei    = e;
    #1;
    chk(nm, "digit eu", {31'd0, dg_eu}, {31'd0, eeu});
    @(posedge clock);
    #1;
    chk(nm, "digit q", {28'd0, dg_q}, {28'd0, eq});
  endtask

  vec_t vecs[$];

  initial begin
    int m;
    int nm_cnt;
    int cycles;
    logic e;

    reset = 1'b1; load = 1'b0; d = '0; start = 1'b0; ei = 1'b0;
    dg_reset = 1'b1; dg_load = 1'b0; dg_d = '0; dg_ei = 1'b0;
    repeat (2) @(posedge clock);

    //            rst   ld    st    ei    d         q         zero  done  eu
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "reset"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'hF0A3, 16'h9093, 1'b0, 1'b0, 1'b0, "clamp_load"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, "load_start"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, "idle_ei"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, "start"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b0, "ei1"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b0, "ei0a"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b0, "ei0b"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0, "ei1b"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, "ei1c"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "run_reload"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "start_zero"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "exp_ei"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "exp_start"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0042, 1'b0, 1'b0, 1'b0, "load42"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0042, 1'b0, 1'b0, 1'b0, "start42"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "reset_run"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "post_reset"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "start_zero2"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, "load1"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, "start1"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "one_to_zero"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "hold_expired"});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].st, vecs[i].e, vecs[i].dv,
           vecs[i].eq, vecs[i].ez, vecs[i].ed, vecs[i].eeu, vecs[i].nm);
    end

    // Long countdown from 0103 with a random pause pattern; expectations come
    // from a plain decimal counter converted to BCD.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0103, 16'h0103, 1'b0, 1'b0, 1'b0, "load103");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0103, 1'b0, 1'b0, 1'b0, "start103");
    m      = 103;
    cycles = 0;
    while (m > 0 && cycles < 600) begin
      e      = ($urandom_range(0, 3) != 0);
      nm_cnt = e ? m - 1 : m;
      step(1'b0, 1'b0, 1'b0, e, 16'h0000, to_bcd(nm_cnt), (nm_cnt == 0),
           (e && m == 1), 1'b0, "count103");
      m = nm_cnt;
      cycles++;
    end
    if (m != 0) chk("count103", "cycle budget", 32'd1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "after103");

    // Standalone digit cell: borrow out and 0 -> 9 wrap.
    dstep(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, "dg_reset");
    dstep(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, "dg_wrap");
    dstep(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd8, "dg_dec");
    dstep(1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 4'd9, "dg_clamp");
    dstep(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, "dg_hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bcd_down_timer
`default_nettype wire

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Multi-digit base-10 (BCD) down counter. It is the decrementing counterpart of the team's base-10 up counter: borrow chain instead of carry chain.
- Adds preset load and a small run/expire state machine. The result is a countdown timer for sequencing and timeout logic elsewhere in the design.
- Digits are cascaded least-significant first. Each digit borrows from the next when it wraps from 0 to 9.

Parameters:
DIGITS, 4, number of BCD digits; count width is 4*DIGITS bits.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
load  input  1  preset strobe; loads d into the count
d  input  4*DIGITS  BCD preset value; digit i sits in d[4i+3:4i]
start  input  1  moves IDLE to RUN
ei  input  1  decrement enable / borrow in; decrement occurs only in RUN
eu  output  1  borrow out; combinational; eu = ei & (count == 0) & (state == RUN)
q  output  4*DIGITS  current BCD count; digit i sits in q[4i+3:4i]
zero  output  1  registered; high when count == 0
done  output  1  registered one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset:
  - While reset = 1 at a rising edge: state = IDLE, q = 0, zero = 1, done = 0.
  - Reset overrides every other input in the same cycle, including mid-RUN.
- States: IDLE, RUN, EXPIRED.
- IDLE:
  - load = 1 loads d. Any preset digit > 9 is clamped to 9.
  - start = 1 with load = 0 and count != 0 goes to RUN.
  - start = 1 with count == 0 goes directly to EXPIRED and pulses done.
  - load and start in the same cycle: load wins; state stays IDLE.
- RUN:
  - ei = 1 decrements the count by 1 per cycle; latency 1 (q updates at the next edge).
  - Digit rule: if the digit is nonzero, it decrements. If the digit is 0 and its borrow-in is 1, it becomes 9 and asserts its borrow-out. Digit i's borrow-in = ei & (all lower digits == 0).
  - ei = 0 holds the count (pause).
  - When a decrement takes the count from 1 to 0, the next state is EXPIRED and done = 1 for exactly one cycle, aligned with q == 0.
  - load = 1 in RUN reloads d (clamped) and returns to IDLE; no decrement that cycle.
- EXPIRED:
  - The count holds at 0 and ei is ignored for counting.
  - eu remains 0 because state != RUN.
  - load returns to IDLE with the new preset. start alone has no effect.
- Wrap: the count never wraps below 0 under FSM control. Wrap 0 to 9...9 is possible only at the digit-cell level (see eu).
- zero reflects the registered count: it updates in the same cycle as q.
- done is never asserted outside the EXPIRED entry cycle; done = 0 on reset.
- Width: q is always valid BCD after reset or load. No binary arithmetic carries between nibbles.

Decomposition:
- Shared package:
  - state encoding constants (IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2)
  - BCD constants (DIGIT_MAX = 4'd9, DIGIT_W = 4)
  - clamp function for a preset digit
- Sub-module b10_down_digit, one per digit, generated DIGITS times:
  - Inputs: clock, reset, load, d[3:0], ei (borrow in).
  - Outputs: q[3:0], eu (borrow out = ei & q == 0).
  - It is the down-counting counterpart of the single up-counting digit.
- The top level holds the FSM, the borrow chain wiring, and the zero/done registers.

Test Plan:
- Reset during RUN at count 0042 (reset = 1 for one edge) -> q = 0000, state IDLE, zero = 1, done = 0 at that edge.
- Load d = 0x0103, start, ei = 1 held -> q sequence 0103, 0102, 0101, 0100, 0099 (digit-1 and digit-2 borrow at 0100 to 0099), ..., 0001, 0000. done pulses for one cycle with q = 0000 after 103 decrements; state EXPIRED.
- Load 0x0005, start, toggle ei 1,0,0,1,1 -> q = 0004, 0004, 0004, 0003, 0002 (pause holds value).
- Load d = 0xF0A3 (invalid digits) -> q = 0x9093 after clamp. Load + start in the same cycle -> state IDLE, no decrement.
- Start with count 0000 -> next edge done = 1, state EXPIRED, eu = 0 throughout. A subsequent ei = 1 leaves q = 0000.
- In RUN at count 0000 via forced digit-cell test (DIGITS = 1, b10_down_digit standalone, ei = 1, q = 0) -> eu = 1 combinationally, next q = 9.
